// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one SRAM port between VGA (default owner) and three
//            requesters (UART, M1, M2). Define ARB_ROUND_ROBIN_EN for
//            round-robin arbitration; otherwise fixed priority UART>M1>M2.
// Revision : 1.0
// ============================================================================
module sram_arbiter (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [53:0] req_address,
  input  logic [47:0] req_write_data,
  input  logic [2:0]  req_we_n,
  input  logic [17:0] vga_address,
  output logic [2:0]  grant,
  output logic        vga_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [25:0] grant_cycles
);

  typedef enum logic [1:0] {
    S_VGA     = 2'd0,
    S_SWITCH  = 2'd1,
    S_OWNED   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [25:0] C_CNT_MAX = 26'h3FF_FFFF;

  state_t      r_state;
  logic [1:0]  r_winner;
  logic [25:0] r_count;
  logic [17:0] r_hold_addr;
  logic [2:0]  r_grant;
  logic        r_vga_enable;
  logic [25:0] r_grant_cycles;

  logic [17:0] w_win_addr;
  logic [15:0] w_win_data;
  logic        w_win_we_n;
  logic        w_win_req;
  logic        w_win_done;
  logic [2:0]  w_win_onehot;
  logic [2:0]  w_rel_req;
  logic [1:0]  w_pick_idle;
  logic [1:0]  w_pick_rel;
  logic [25:0] w_count_inc;

  // Select the current winner's request fields.
  always_comb begin
    w_win_addr   = req_address[17:0];
    w_win_data   = req_write_data[15:0];
    w_win_we_n   = req_we_n[0];
    w_win_req    = req[0];
    w_win_done   = done[0];
    w_win_onehot = 3'b001;
    case (r_winner)
      2'd1: begin
        w_win_addr   = req_address[35:18];
        w_win_data   = req_write_data[31:16];
        w_win_we_n   = req_we_n[1];
        w_win_req    = req[1];
        w_win_done   = done[1];
        w_win_onehot = 3'b010;
      end
      2'd2: begin
        w_win_addr   = req_address[53:36];
        w_win_data   = req_write_data[47:32];
        w_win_we_n   = req_we_n[2];
        w_win_req    = req[2];
        w_win_done   = done[2];
        w_win_onehot = 3'b100;
      end
      default: ;
    endcase
  end

  // The releasing owner is masked out so it cannot be regranted back-to-back.
  assign w_rel_req   = req & ~w_win_onehot;
  assign w_count_inc = (r_count == C_CNT_MAX) ? C_CNT_MAX : r_count + 26'd1;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_rr_ptr;

  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [2:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, start} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && r[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
  endfunction

  assign w_pick_idle = pick(req, r_rr_ptr);
  assign w_pick_rel  = pick(w_rel_req, r_rr_ptr);
`else
  function automatic logic [1:0] pick(input logic [2:0] r);
    if (r[0])      pick = 2'd0;
    else if (r[1]) pick = 2'd1;
    else if (r[2]) pick = 2'd2;
    else           pick = 2'd0;
  endfunction

  assign w_pick_idle = pick(req);
  assign w_pick_rel  = pick(w_rel_req);
`endif

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_VGA;
      r_winner       <= 2'd0;
      r_count        <= 26'd0;
      r_hold_addr    <= 18'd0;
      r_grant        <= 3'b000;
      r_vga_enable   <= 1'b1;
      r_grant_cycles <= 26'd0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr       <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_VGA: begin
          if (|req) begin
            r_winner     <= w_pick_idle;
            r_vga_enable <= 1'b0;
            r_state      <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          if (w_win_req) begin
            r_state <= S_OWNED;
            r_grant <= w_win_onehot;
            r_count <= 26'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr <= (r_winner == 2'd2) ? 2'd0 : r_winner + 2'd1;
`endif
          end else begin
            r_state      <= S_VGA;
            r_vga_enable <= 1'b1;
          end
        end
        S_OWNED: begin
          r_hold_addr <= w_win_addr;
          if (w_win_done) begin
            r_state        <= S_RELEASE;
            r_grant        <= 3'b000;
            r_grant_cycles <= w_count_inc;
          end else begin
            r_count <= w_count_inc;
          end
        end
        S_RELEASE: begin
          if (|w_rel_req) begin
            r_winner <= w_pick_rel;
            r_state  <= S_SWITCH;
          end else begin
            r_state      <= S_VGA;
            r_vga_enable <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_VGA;
          r_grant      <= 3'b000;
          r_vga_enable <= 1'b1;
        end
      endcase
    end
  end

  // Data path follows the state combinationally so an owner sees no added latency.
  always_comb begin
    SRAM_address    = vga_address;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (r_state)
      S_SWITCH:  SRAM_address = w_win_addr;
      S_OWNED: begin
        SRAM_address    = w_win_addr;
        SRAM_write_data = w_win_data;
        SRAM_we_n       = w_win_we_n;
      end
      S_RELEASE: SRAM_address = r_hold_addr;
      default: ;
    endcase
  end

  assign grant        = r_grant;
  assign vga_enable   = r_vga_enable;
  assign grant_cycles = r_grant_cycles;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Self-checking bench for sram_arbiter (vector table, directed
//            sequences, randomized traffic against a behavioural model).
// Revision : 1.0
// ============================================================================
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req, done, req_we_n;
  logic [53:0] req_address;
  logic [47:0] req_write_data;
  logic [17:0] vga_address;
  logic [2:0]  grant;
  logic        vga_enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [25:0] grant_cycles;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  sram_arbiter dut (
    .CLOCK_50_I      (clk),
    .resetn          (resetn),
    .req             (req),
    .done            (done),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_we_n        (req_we_n),
    .vga_address     (vga_address),
    .grant           (grant),
    .vga_enable      (vga_enable),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .grant_cycles    (grant_cycles)
  );

  // Behavioural model: who holds the SRAM, and when the current grant began.
  localparam int M_VGA = 0, M_SW = 1, M_OWN = 2, M_REL = 3;
  int          m_state, m_win, m_ptr;
  longint      cyc, m_start, m_gc;
  logic [17:0] m_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] addr_of(input int i);
    return req_address[i*18 +: 18];
  endfunction

  function automatic logic [15:0] data_of(input int i);
    return req_write_data[i*16 +: 16];
  endfunction

  function automatic int pick(input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      int i;
`ifdef ARB_ROUND_ROBIN_EN
      i = (m_ptr + k) % 3;
`else
      i = k;
`endif
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_check();
    logic [2:0]  eg;
    logic [17:0] ea;
    logic [15:0] ed;
    logic        ew;
    eg = 3'b000; ea = vga_address; ed = 16'd0; ew = 1'b1;
    case (m_state)
      M_SW:  ea = addr_of(m_win);
      M_OWN: begin
        eg = 3'(1 << m_win);
        ea = addr_of(m_win);
        ed = data_of(m_win);
        ew = req_we_n[m_win];
      end
      M_REL: ea = m_hold;
      default: ;
    endcase
    chk("m_grant", grant, eg);
    chk("m_vga_enable", vga_enable, (m_state == M_VGA));
    chk("m_addr", SRAM_address, ea);
    chk("m_wdata", SRAM_write_data, ed);
    chk("m_we_n", SRAM_we_n, ew);
    chk("m_grant_cycles", grant_cycles, m_gc[25:0]);
  endtask

  task automatic model_step();
    logic [2:0] masked;
    case (m_state)
      M_VGA: if (req != 3'b000) begin m_win = pick(req); m_state = M_SW; end
      M_SW: begin
        if (req[m_win]) begin
          m_state = M_OWN;
          m_start = cyc + 1;
          m_ptr   = (m_win + 1) % 3;
        end else m_state = M_VGA;
      end
      M_OWN: begin
        if (done[m_win]) begin
          m_gc    = cyc - m_start + 1;
          m_hold  = addr_of(m_win);
          m_state = M_REL;
        end
      end
      default: begin
        masked = req & ~3'(1 << m_win);
        if (masked != 3'b000) begin m_win = pick(masked); m_state = M_SW; end
        else m_state = M_VGA;
      end
    endcase
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    m_state = M_VGA; m_win = 0; m_ptr = 0; m_gc = 0; m_hold = '0; m_start = 0;
    chk("rst_grant", grant, 3'b000);
    chk("rst_vga_enable", vga_enable, 1'b1);
    chk("rst_we_n", SRAM_we_n, 1'b1);
    chk("rst_addr", SRAM_address, vga_address);
    chk("rst_grant_cycles", grant_cycles, 26'd0);
    repeat (2) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req, done, we_n;
    logic [17:0] vga;
    logic [2:0]  e_grant;
    logic        e_vga;
    logic        e_we_n;
    logic [17:0] e_addr;
    logic [25:0] e_gc;
  } vec_t;

  vec_t tbl[15];
  int   exp_order[4];

  initial begin
    logic [63:0] r64;
    int          idx;

    resetn = 1'b0; req = '0; done = '0; req_we_n = 3'b111; vga_address = '0; cyc = 0;
    req_address    = {18'h03333, 18'h02222, 18'h01111};
    req_write_data = {16'hCCC3, 16'hBBB2, 16'hAAA1};

    // M1 single grant: switch at 1, owned 2..12, stray done at 5, done at 12.
    for (int i = 0; i < 15; i++) begin
      tbl[i].req = 3'b010; tbl[i].done = 3'b000; tbl[i].we_n = 3'b101;
      tbl[i].vga = 18'h00100 + 18'(i);
      tbl[i].e_grant = 3'b010; tbl[i].e_vga = 1'b0; tbl[i].e_we_n = 1'b0;
      tbl[i].e_addr = 18'h02222; tbl[i].e_gc = 26'd0;
    end
    tbl[0].e_grant = 3'b000; tbl[0].e_vga = 1'b1; tbl[0].e_we_n = 1'b1; tbl[0].e_addr = tbl[0].vga;
    tbl[1].e_grant = 3'b000; tbl[1].e_we_n = 1'b1;
    tbl[5].done  = 3'b101;
    tbl[12].done = 3'b010;
    for (int i = 13; i < 15; i++) begin
      tbl[i].req = 3'b000; tbl[i].e_grant = 3'b000; tbl[i].e_we_n = 1'b1; tbl[i].e_gc = 26'd11;
    end
    tbl[14].e_vga = 1'b1; tbl[14].e_addr = tbl[14].vga;

`ifdef ARB_ROUND_ROBIN_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif

    @(posedge clk); #1;
    do_reset();

    // Idle: SRAM address follows VGA every cycle.
    repeat (4) begin
      vga_address = 18'($urandom);
      #1;
      chk("idle_addr", SRAM_address, vga_address);
      tick();
    end

    do_reset();
    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req; done = tbl[i].done; req_we_n = tbl[i].we_n; vga_address = tbl[i].vga;
      #1;
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("vec%0d_vga_enable", i), vga_enable, tbl[i].e_vga);
      chk($sformatf("vec%0d_we_n", i), SRAM_we_n, tbl[i].e_we_n);
      chk($sformatf("vec%0d_addr", i), SRAM_address, tbl[i].e_addr);
      chk($sformatf("vec%0d_grant_cycles", i), grant_cycles, tbl[i].e_gc);
      tick();
    end
    req = '0; done = '0; req_we_n = 3'b111;

    // All three requesting continuously; owners release after three cycles.
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      idx = -1;
      for (int t = 0; t < 12 && idx < 0; t++) begin
        #1;
        if (grant != 3'b000) idx = (grant == 3'b001) ? 0 : (grant == 3'b010) ? 1 : 2;
        else tick();
      end
      if (idx < 0) begin
        checks++; errors++;
        $display("FAIL order%0d_timeout actual=no_grant expected=grant", g);
        break;
      end
      chk($sformatf("order%0d", g), idx, exp_order[g]);
      tick(); tick();
      done = 3'(1 << idx);
      tick();
      done = '0;
    end
    req = '0;
    repeat (3) tick();

    // One-cycle request pulse is abandoned in the switch cycle.
    do_reset();
    req = 3'b001; req_we_n = 3'b000;
    #1; chk("pulse_vga_enable0", vga_enable, 1'b1);
    tick();
    req = 3'b000;
    #1;
    chk("pulse_sw_vga_enable", vga_enable, 1'b0);
    chk("pulse_sw_grant", grant, 3'b000);
    chk("pulse_sw_we_n", SRAM_we_n, 1'b1);
    chk("pulse_sw_addr", SRAM_address, 18'h01111);
    tick();
    #1;
    chk("pulse_back_vga_enable", vga_enable, 1'b1);
    chk("pulse_back_grant", grant, 3'b000);
    tick();
    req_we_n = 3'b111;

    // Reset asserted in the middle of an M1 write grant.
    do_reset();
    req = 3'b010; req_we_n = 3'b101;
    tick(); tick();
    #1;
    chk("midrst_pre_grant", grant, 3'b010);
    chk("midrst_pre_we_n", SRAM_we_n, 1'b0);
    #2;
    do_reset();
    req = '0; req_we_n = 3'b111;

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      done = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      req_we_n = 3'($urandom);
      r64 = {$urandom(), $urandom()};
      req_address = r64[53:0];
      r64 = {$urandom(), $urandom()};
      req_write_data = r64[47:0];
      vga_address = 18'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
